// File: rtl/count_job_scheduler_if.sv
// count_job_scheduler_if: request/length/abort inputs and grant/count/done outputs
// shared between a client pair and the scheduler.
interface count_job_scheduler_if #(parameter int WIDTH = 8);
  logic [1:0]       req;
  logic [WIDTH-1:0] len0;
  logic [WIDTH-1:0] len1;
  logic             abort;
  logic [1:0]       gnt;
  logic             busy;
  logic [WIDTH-1:0] cnt;
  logic [1:0]       done;
  modport master (output req, len0, len1, abort, input gnt, busy, cnt, done);
  modport slave  (input req, len0, len1, abort, output gnt, busy, cnt, done);
endinterface

// File: rtl/count_job_scheduler.sv
// count_job_scheduler: round-robin arbiter granting one built-in down-counter to two requesters.
module count_job_scheduler #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  count_job_scheduler_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       state, gnt, done;
  logic             busy, last, win;
  logic [WIDTH-1:0] cnt;
  // On a tie the requester not served last wins; otherwise the lone requester wins.
  always_comb win = &bus.req ? ~last : bus.req[1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= 1'b1;
    end else if (state == IDLE) begin
      if (!bus.abort && |bus.req) begin
        state <= RUN;
        gnt   <= win ? 2'b10 : 2'b01;
        cnt   <= win ? bus.len1 : bus.len0;
        busy  <= 1'b1;
      end
    end else if (bus.abort || state == DONE) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
      cnt   <= '0;
      last  <= gnt[1];
    end else if (cnt <= 1) begin
      state <= DONE;
      cnt   <= '0;
      done  <= gnt;
    end else begin
      cnt <= cnt - 1'b1;
    end
  assign bus.gnt  = gnt;
  assign bus.done = done;
  assign bus.busy = busy;
  assign bus.cnt  = cnt;
endmodule

// File: tb/tb_count_job_scheduler.sv
// tb_count_job_scheduler: scenario tasks plus randomized traffic, checked against a
// job-timeline model (cycles elapsed since grant) of the scheduler.
module tb_count_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int fails = 0;
  count_job_scheduler_if #(.WIDTH(8)) bus ();
  count_job_scheduler #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  wire [12:0] dut_out = {bus.gnt, bus.busy, bus.cnt, bus.done};
  bit m_active = 0;
  bit m_win = 0;
  bit m_last = 1;
  int m_len = 0;
  int m_k = 0;
  function automatic int leff();
    return (m_len == 0) ? 1 : m_len;
  endfunction
  function automatic logic [12:0] exp_out();
    logic [1:0] g;
    logic [7:0] c;
    if (!m_active) return '0;
    g = m_win ? 2'b10 : 2'b01;
    c = (m_k < leff()) ? 8'(m_len - m_k) : 8'd0;
    return {g, 1'b1, c, (m_k == leff()) ? g : 2'b00};
  endfunction
  task automatic model_reset();
    m_active = 0;
    m_last = 1;
  endtask
  task automatic model_edge();
    if (rst) model_reset();
    else if (!m_active) begin
      if (!bus.abort && bus.req != 2'b00) begin
        m_win = (bus.req == 2'b11) ? !m_last : bus.req[1];
        m_len = m_win ? int'(bus.len1) : int'(bus.len0);
        m_k = 0;
        m_active = 1;
      end
    end else if (bus.abort || m_k == leff()) begin
      m_active = 0;
      m_last = m_win;
    end else m_k++;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic drain();
    bus.req = 2'b00;
    bus.abort = 1'b0;
    for (int i = 0; i < 300 && m_active; i++) begin
      step(); vectors++;
      if (dut_out !== exp_out()) begin fails++; $display("FAIL drain: got %h exp %h", dut_out, exp_out()); end
    end
    vectors++;
    if (m_active) begin fails++; $display("FAIL drain_timeout: job still active exp idle"); end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 2'b00; bus.len0 = '0; bus.len1 = '0; bus.abort = 1'b0;
    model_reset();
    step(); step();
    vectors++;
    if (dut_out !== 13'h0) begin fails++; $display("FAIL reset: got %h exp 0", dut_out); end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_single();
    int dones = 0;
    bus.req = 2'b01; bus.len0 = 8'd3;
    for (int i = 0; i < 6; i++) begin
      step(); vectors++;
      if (dut_out !== exp_out()) begin fails++; $display("FAIL single: got %h exp %h", dut_out, exp_out()); end
      if (bus.done == 2'b01 && bus.cnt == 8'd0) dones++;
      if (i == 0) bus.req = 2'b00;
    end
    vectors++;
    if (dones != 1) begin fails++; $display("FAIL single_done_count: got %0d exp 1", dones); end
    drain();
  endtask
  task automatic test_round_robin();
    logic [1:0] order[$];
    logic [1:0] prev = 2'b00;
    logic [1:0] want[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    test_reset();
    bus.req = 2'b11; bus.len0 = 8'd2; bus.len1 = 8'd4;
    for (int i = 0; i < 24; i++) begin
      step(); vectors++;
      if (dut_out !== exp_out()) begin fails++; $display("FAIL round_robin: got %h exp %h", dut_out, exp_out()); end
      if (prev == 2'b00 && bus.gnt != 2'b00) order.push_back(bus.gnt);
      prev = bus.gnt;
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (order.size() <= i || order[i] !== want[i]) begin fails++; $display("FAIL rr_order[%0d]: got %b exp %b", i, (order.size() > i) ? order[i] : 2'bxx, want[i]); end
    end
    drain();
  endtask
  task automatic test_zero_len();
    bus.req = 2'b10; bus.len1 = 8'd0;
    for (int i = 0; i < 4; i++) begin
      step(); vectors++;
      if (dut_out !== exp_out()) begin fails++; $display("FAIL zero_len: got %h exp %h", dut_out, exp_out()); end
      if (i == 1) begin
        vectors++;
        if (bus.done !== 2'b10) begin fails++; $display("FAIL zero_len_done: got %b exp 10", bus.done); end
      end
    end
    drain();
  endtask
  task automatic test_abort_mid();
    bus.req = 2'b01; bus.len0 = 8'd5;
    step(); step(); step();
    vectors++;
    if (bus.cnt !== 8'd3) begin fails++; $display("FAIL abort_mid_cnt: got %0d exp 3", bus.cnt); end
    bus.abort = 1'b1;
    step(); vectors++;
    if (dut_out !== exp_out() || dut_out !== 13'h0) begin fails++; $display("FAIL abort_mid: got %h exp %h", dut_out, exp_out()); end
    bus.abort = 1'b0; bus.req = 2'b11; bus.len1 = 8'd2;
    step(); vectors++;
    if (bus.gnt !== 2'b10 || dut_out !== exp_out()) begin fails++; $display("FAIL abort_next_grant: got %h exp %h", dut_out, exp_out()); end
    drain();
  endtask
  task automatic test_abort_collide();
    bus.req = 2'b01; bus.len0 = 8'd2;
    step(); bus.req = 2'b00;
    step(); vectors++;
    if (bus.cnt !== 8'd1) begin fails++; $display("FAIL collide_cnt: got %0d exp 1", bus.cnt); end
    bus.abort = 1'b1;
    step(); vectors++;
    if (dut_out !== exp_out() || bus.done !== 2'b00) begin fails++; $display("FAIL collide: got %h exp %h", dut_out, exp_out()); end
    bus.abort = 1'b0;
    step(); vectors++;
    if (dut_out !== 13'h0) begin fails++; $display("FAIL collide_after: got %h exp 0", dut_out); end
    drain();
  endtask
  task automatic test_async_reset();
    bus.req = 2'b01; bus.len0 = 8'd6;
    step(); step(); step();
    bus.req = 2'b00;
    vectors++;
    if (bus.cnt !== 8'd4) begin fails++; $display("FAIL async_cnt: got %0d exp 4", bus.cnt); end
    #2 rst = 1'b1;
    model_reset();
    #1 vectors++;
    if (dut_out !== 13'h0) begin fails++; $display("FAIL async_clear: got %h exp 0", dut_out); end
    step();
    #3 rst = 1'b0;
    bus.req = 2'b11; bus.len0 = 8'd1; bus.len1 = 8'd1;
    step(); vectors++;
    if (bus.gnt !== 2'b01 || dut_out !== exp_out()) begin fails++; $display("FAIL async_first_grant: got %h exp %h", dut_out, exp_out()); end
    drain();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.req = 2'($urandom_range(0, 3));
      bus.len0 = 8'($urandom_range(0, 9));
      bus.len1 = 8'($urandom_range(0, 9));
      bus.abort = ($urandom_range(0, 9) == 0);
      step(); vectors++;
      if (dut_out !== exp_out()) begin fails++; $display("FAIL random[%0d]: got %h exp %h", i, dut_out, exp_out()); end
    end
    drain();
  endtask
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_abort_mid();
    test_abort_collide();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/count_job_scheduler.md
# count_job_scheduler

Round-robin scheduler that shares one down-counter between two requesters. Each requester asks for a countdown of a given length; the block grants the counter to one requester at a time and runs the count. When the count completes it pulses done back to the granted requester. It sits between the control logic of two client blocks and the counter datapath, which is built into this block as a WIDTH-bit synchronous down-counter.

## Interface
- WIDTH, 8, counter and length width in bits

- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-high; clock clk
- req  in  2  per-requester request; req[i] asks for a countdown of len_i
- len0  in  WIDTH  count length for requester 0, sampled only at grant
- len1  in  WIDTH  count length for requester 1, sampled only at grant
- abort  in  1  synchronous cancel of the current job
- gnt  out  2  one-hot grant, registered; 2'b00 when idle
- busy  out  1  high in RUN and DONE
- cnt  out  WIDTH  current counter value, registered
- done  out  2  one-cycle completion pulse to the granted requester

## Operation
- Reset values: state IDLE, gnt=2'b00, done=2'b00, busy=0, cnt=0, last_served=1 (so requester 0 wins first).
- rst asserted at any time, including mid-job, forces reset values immediately. No done pulse is produced.
- States are IDLE, RUN and DONE, tracked internally.
- **IDLE**
  - If abort=0 and any req bit is high at a clock edge: pick the winner, load cnt=len_winner, set gnt[winner]=1 and busy=1, go to RUN.
  - abort=1 in IDLE blocks granting on that edge and has no other effect.
- **Arbitration**
  - Only one req bit high: that requester wins.
  - Both high: the requester not equal to last_served wins.
- **RUN**
  - At each edge: if cnt<=1, set cnt=0 and go to DONE. Otherwise cnt=cnt-1.
  - len=0 behaves like len=1.
  - Arithmetic is unsigned. cnt never wraps below 0.
- **DONE**
  - Lasts exactly one cycle. done[winner]=1, gnt held, busy=1.
  - Next edge: go to IDLE, gnt=0, done=0, busy=0, cnt stays 0, last_served=winner.
- **Abort**
  - abort=1 at an edge in RUN or DONE: go to IDLE, gnt=0, busy=0, cnt=0, done=0, last_served=winner.
  - abort takes priority over completion on the same edge, so no done pulse is produced.
- **Requester behaviour**
  - Dropping req while granted is ignored; the job runs to completion.
  - A requester that keeps req high after done is re-eligible from IDLE, subject to round-robin.
  - len inputs are not re-sampled during RUN.

## Timing
- Grant latency: req sampled high in IDLE at edge E means gnt, busy and cnt=len are valid after E.
- For length L>=1: cnt counts down L, L-1, … 1 after edges E … E+L-1. State is DONE after edge E+L (cnt=0, done high for that one cycle). gnt and busy fall after edge E+L+1.
- Throughput: there is at least one IDLE cycle between jobs. With req held continuously, the next grant occurs at edge E+L+2.
- Job period for length L is L+2 cycles.
- done is always coincident with gnt on the same bit and is never asserted when gnt=0.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Reset and single job:** rst high 2 cycles, then req=2'b01, len0=3. Expect gnt=01 one cycle after the sampling edge, cnt 3,2,1,0, done=01 for exactly one cycle with cnt=0, then gnt=00, busy=0.
- **Round-robin:** req=2'b11 held, len0=2, len1=4. Expect grant order 0,1,0,1. done alternates 01/10. Each grant comes 2 cycles after the previous done edge.
- **Zero length:** req=2'b10, len1=0. Expect one RUN cycle with cnt=0, then done=10 one cycle later, identical to len1=1.
- **Abort mid-job:** len0=5, assert abort when cnt=3. Expect gnt=00, busy=0, cnt=0 next cycle and no done. With req=2'b11 afterwards, requester 1 is granted next.
- **Abort colliding with completion:** abort=1 on the edge where cnt=1. Expect IDLE with done never asserted.
- **Async reset mid-run:** pulse rst between edges while cnt=4. Expect gnt, busy, cnt and done to clear immediately without waiting for clk. After release with req=2'b11, requester 0 is granted first.
